bk_mw_add_ctrl: RTL

Multi-word add/subtract sequencer built around one instance of the team's 32-bit Brent-Kung adder (bk_adder_32bit).
- Accepts a WORDS x 32-bit operand pair over a valid/ready handshake.
- Feeds the operands through the single adder one 32-bit limb per cycle, least-significant limb first, chaining the adder carry-out into the next limb's carry-in.
- Returns the full-width result, carry and signed overflow over a second valid/ready handshake.
- Sits between a wide-arithmetic requester and the shared 32-bit adder datapath.

---
 rtl/bk_mw_add_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bk_mw_add_ctrl.sv
// Multi-word add/subtract sequencer. One shared 32-bit Brent-Kung adder is stepped
// over the operand limbs, LSB first, with the carry chained through a register.

module bk_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g0;
  logic [31:0] p0;
  logic [31:0] gg;
  logic [31:0] pp;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Carry-in is folded into bit 0's generate, so gg[i] ends as the carry out of bit i.
  always_comb begin
    gg    = g0;
    pp    = p0;
    gg[0] = g0[0] | (p0[0] & cin);
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = 0; i < 32; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        end
      end
    end
  end

  assign sum  = p0 ^ {gg[30:0], cin};
  assign cout = gg[31];

endmodule

module bk_mw_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [32*WORDS-1:0] a_i,
  input  logic [32*WORDS-1:0] b_i,
  input  logic                op_sub_i,
  input  logic                cin_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [32*WORDS-1:0] sum_o,
  output logic                cout_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int W  = 32 * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;

  logic [CW+4:0] base;
  logic [31:0]   a_limb;
  logic [31:0]   b_limb;
  logic [31:0]   add_sum;
  logic          add_cout;
  logic          last_limb;
  logic          top_carry;

  assign base      = {cnt, 5'd0};
  assign a_limb    = a_q[base +: 32];
  assign b_limb    = b_q[base +: 32];
  assign last_limb = (cnt == CW'(WORDS - 1));
  assign top_carry = a_limb[31] ^ b_limb[31] ^ add_sum[31];

  bk_adder_32bit u_adder (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial limbs collect in work_q so sum_o only changes when an operation completes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            a_q     <= a_i;
            b_q     <= op_sub_i ? ~b_i : b_i;
            carry_q <= op_sub_i | cin_i;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          work_q[base +: 32] <= add_sum;
          carry_q            <= add_cout;
          if (last_limb) begin
            sum_q  <= {add_sum, work_q[W-33:0]};
            cout_q <= add_cout;
            ovf_q  <= top_carry ^ add_cout;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state == RUN);
  assign rsp_valid_o = (state == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule
